// File: rtl/register_file_if.sv
// Register-file bus: decoder-side addresses, write data and PC alias in,
// two read-data ports out. clk/reset stay plain ports on the register file.
interface register_file_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
);
  logic              WE3;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [ADDR_W-1:0] A3;
  logic [WIDTH-1:0]  WD3;
  logic [WIDTH-1:0]  R15;
  logic [WIDTH-1:0]  RD1;
  logic [WIDTH-1:0]  RD2;

  modport master (
    output WE3, A1, A2, A3, WD3, R15,
    input  RD1, RD2
  );

  modport slave (
    input  WE3, A1, A2, A3, WD3, R15,
    output RD1, RD2
  );
endinterface

// File: rtl/register_file.sv
// register_file: NUM_REGS x WIDTH register file, two combinational read ports,
// one synchronous write port. Index NUM_REGS-1 is a PC alias (reads R15, no
// storage, writes dropped); indices >= NUM_REGS read 0 and ignore writes.
// Optional feature macro: REGFILE_BYPASS_EN enables write-through forwarding
// of WD3 to a read port addressing the register being written this cycle.
module register_file #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input logic             clk,
  input logic             reset,
  register_file_if.slave  bus
);

  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] PC_IDX  = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] NUM_IDX = (ADDR_W+1)'(NUM_REGS);

  logic [WIDTH-1:0] regs [0:NUM_REGS-2];
  logic             wr_ok;

  // Only true storage indices accept writes; the PC alias and out-of-range drop them.
  assign wr_ok = ({1'b0, bus.A3} < PC_IDX);

  function automatic logic [WIDTH-1:0] rd_sel(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    if ({1'b0, a} >= NUM_IDX) begin
      v = '0;
    end else if ({1'b0, a} == PC_IDX) begin
      v = bus.R15;
`ifdef REGFILE_BYPASS_EN
    end else if (bus.WE3 === 1'b1 && !reset && wr_ok && a == bus.A3) begin
      v = bus.WD3;
`endif
    end else begin
      v = regs[a];
    end
    return v;
  endfunction

  // Storage update: async clear dominates; an unknown WE3 fails the test and leaves storage intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.WE3 && wr_ok) begin
      regs[bus.A3] <= bus.WD3;
    end
  end

  // Both read ports decode their address against storage, the PC alias and the range limit.
  always_comb begin
    bus.RD1 = rd_sel(bus.A1);
    bus.RD2 = rd_sel(bus.A2);
  end

`ifndef SYNTHESIS
  // Flag an unknown write enable outside reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(bus.WE3));
    end
  end
`endif

endmodule
